// File: rtl/keypad_interrupt_capture.sv
// Keypad front end: two-flop synchroniser, per-key debounce, sticky press events with
// masked software clear, overrun flags and a registered any-interrupt summary.
module keypad_interrupt_capture #(
   parameter int NUM_KEYS        = 20,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   input  logic                clr_valid,
   input  logic [NUM_KEYS-1:0] clr_mask,
   output logic [NUM_KEYS-1:0] interrupt,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] overrun,
   output logic                irq_any
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] s1_q, s1_d;
   logic [NUM_KEYS-1:0] s2_q, s2_d;
   logic [NUM_KEYS-1:0] stable_q, stable_d;
   logic [NUM_KEYS-1:0] interrupt_q, interrupt_d;
   logic [NUM_KEYS-1:0] overrun_q, overrun_d;
   logic                irq_any_q, irq_any_d;
   logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
   logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] clr_hit;

   always_comb begin
      s1_d     = key_raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      press    = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         // Any cycle agreeing with the accepted level restarts the count.
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = s2_q[i];
               press[i]    = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      clr_hit     = clr_valid ? clr_mask : '0;
      interrupt_d = interrupt_q;
      overrun_d   = overrun_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
         // A press beats a clear; a clear on the same edge consumes the old event.
         if (press[i]) begin
            interrupt_d[i] = 1'b1;
            if (interrupt_q[i] && !clr_hit[i]) begin
               overrun_d[i] = 1'b1;
            end
         end else if (clr_hit[i]) begin
            interrupt_d[i] = 1'b0;
            overrun_d[i]   = 1'b0;
         end
      end
      irq_any_d = |interrupt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q        <= '0;
         s2_q        <= '0;
         stable_q    <= '0;
         interrupt_q <= '0;
         overrun_q   <= '0;
         irq_any_q   <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         stable_q    <= stable_d;
         interrupt_q <= interrupt_d;
         overrun_q   <= overrun_d;
         irq_any_q   <= irq_any_d;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign interrupt = interrupt_q;
   assign key_level = stable_q;
   assign overrun   = overrun_q;
   assign irq_any   = irq_any_q;

endmodule

// File: tb/tb_keypad_interrupt_capture.sv
// Bench for keypad_interrupt_capture: directed scenarios plus random key/clear/reset
// traffic, every cycle compared against a run-length behavioural model.
module tb_keypad_interrupt_capture;

   localparam int NK = 20;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NK-1:0] key_raw;
   logic          clr_valid;
   logic [NK-1:0] clr_mask;
   logic [NK-1:0] interrupt;
   logic [NK-1:0] key_level;
   logic [NK-1:0] overrun;
   logic          irq_any;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [NK-1:0] m_s1, m_s2, m_lvl, m_int, m_ovr;
   logic          m_any;
   int            m_run [NK];

   keypad_interrupt_capture #(
      .NUM_KEYS(NK),
      .DEBOUNCE_CYCLES(DC),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .key_raw(key_raw),
      .clr_valid(clr_valid),
      .clr_mask(clr_mask),
      .interrupt(interrupt),
      .key_level(key_level),
      .overrun(overrun),
      .irq_any(irq_any)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_int = '0; m_ovr = '0; m_any = 1'b0;
      for (int i = 0; i < NK; i++) m_run[i] = 0;
   endtask

   // One clock edge of the model, using input values held before the edge.
   task automatic model_step();
      logic [NK-1:0] pr;
      logic [NK-1:0] clr;
      if (!reset_n) begin
         model_reset();
      end else begin
         pr    = '0;
         clr   = clr_valid ? clr_mask : '0;
         m_any = (m_int != '0);
         for (int i = 0; i < NK; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == DC) begin
                  m_lvl[i] = m_s2[i];
                  m_run[i] = 0;
                  pr[i]    = m_s2[i];
               end
            end else begin
               m_run[i] = 0;
            end
         end
         for (int i = 0; i < NK; i++) begin
            if (pr[i]) begin
               if (m_int[i] && !clr[i]) m_ovr[i] = 1'b1;
               m_int[i] = 1'b1;
            end else if (clr[i]) begin
               m_int[i] = 1'b0;
               m_ovr[i] = 1'b0;
            end
         end
         m_s2 = m_s1;
         m_s1 = key_raw;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
         chk("interrupt", interrupt, m_int);
         chk("key_level", key_level, m_lvl);
         chk("overrun", overrun, m_ovr);
         chk("irq_any", irq_any, m_any);
      end
   endtask

   task automatic clear_pulse(input logic [NK-1:0] m);
      clr_valid = 1'b1;
      clr_mask  = m;
      step(1);
      clr_valid = 1'b0;
      clr_mask  = '0;
   endtask

   initial begin
      model_reset();
      reset_n   = 1'b1;
      key_raw   = '1;
      clr_valid = 1'b0;
      clr_mask  = '0;
      #2 reset_n = 1'b0;

      // Reset with every key held
      step(3);
      chk("rst_int", interrupt, 0);
      chk("rst_lvl", key_level, 0);
      chk("rst_any", irq_any, 0);
      reset_n = 1'b1;
      step(5);
      chk("held_e5", interrupt, 0);
      step(1);
      chk("held_int_e6", interrupt, 20'hFFFFF);
      chk("held_lvl_e6", key_level, 20'hFFFFF);
      chk("held_any_e6", irq_any, 0);
      step(1);
      chk("held_any_e7", irq_any, 1);
      key_raw = '0;
      step(8);
      clear_pulse(20'hFFFFF);
      step(1);
      chk("clrall_int", interrupt, 0);
      chk("clrall_any", irq_any, 0);

      // Clean press of key 3
      key_raw = 20'h00008;
      step(5);
      chk("k3_e5", interrupt, 0);
      step(1);
      chk("k3_e6", interrupt, 20'h00008);
      clear_pulse(20'h00008);
      chk("k3_clr_int", interrupt, 0);
      step(1);
      chk("k3_clr_any", irq_any, 0);
      key_raw = '0;
      step(8);

      // Bounce on key 7
      for (int c = 0; c < 40; c++) begin
         key_raw[7] = (c % 4 != 3);
         step(1);
         chk("bounce_lvl7", key_level[7], 0);
         chk("bounce_int7", interrupt[7], 0);
      end
      key_raw[7] = 1'b1;
      step(5);
      chk("bounce_e5", interrupt[7], 0);
      step(1);
      chk("bounce_e6", interrupt[7], 1);
      key_raw = '0;
      clear_pulse(20'h00080);
      step(8);

      // Press of key 0 colliding with its clear
      key_raw[0] = 1'b1;
      step(6);
      chk("k0_first", interrupt[0], 1);
      key_raw[0] = 1'b0;
      step(8);
      key_raw[0] = 1'b1;
      step(5);
      clr_valid = 1'b1;
      clr_mask  = 20'h00001;
      step(1);
      clr_valid = 1'b0;
      clr_mask  = '0;
      chk("coll_int0", interrupt[0], 1);
      chk("coll_ovr0", overrun[0], 0);
      key_raw = '0;
      clear_pulse(20'h00001);
      step(8);

      // Overrun on key 12
      key_raw = 20'h01000;
      step(6);
      key_raw = '0;
      step(8);
      key_raw = 20'h01000;
      step(6);
      chk("ovr_set", overrun, 20'h01000);
      clear_pulse(20'h01000);
      chk("ovr_clr_int12", interrupt[12], 0);
      chk("ovr_clr_ovr", overrun, 0);
      key_raw = '0;
      step(8);

      // Reset mid-debounce on key 19
      key_raw = 20'h80000;
      step(2);
      chk("k19_pre", interrupt, 0);
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(5);
      chk("k19_e5", interrupt, 0);
      step(1);
      chk("k19_e6", interrupt, 20'h80000);
      key_raw = '0;
      step(8);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NK; i++) begin
            if ($urandom_range(0, 9) == 0) key_raw[i] = ~key_raw[i];
         end
         clr_valid = ($urandom_range(0, 4) == 0);
         clr_mask  = NK'($urandom);
         reset_n   = ($urandom_range(0, 399) != 0);
         step(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
